// File: rtl/systolic_output_collector.sv
// systolic_output_collector: deskews per-column systolic results into a row buffer and drains it row by row
module systolic_output_collector #(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int WORD_SIZE   = 16,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [COLS*WORD_SIZE-1:0]     bottom_out,
    input  logic [COLS-1:0]               output_col_valid,
    output logic [COLS*WORD_SIZE-1:0]     out_row_data,
    output logic [$clog2(ROWS):0]         out_row_idx,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          overrun
);
    localparam int IW  = $clog2(ROWS) + 1;
    localparam int AW  = $clog2(ROWS);
    localparam int PHW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    state_t               state;
    logic [IW-1:0]        row_ptr [COLS];
    logic [PHW-1:0]       phase   [COLS];
    logic [WORD_SIZE-1:0] rbuf    [ROWS][COLS];
    logic [COLS-1:0]      cap, extra, full_next;

    assign busy = (state != IDLE);

    // per-column sample decision: one sample on the first cycle of each hold window
    always_comb begin
        cap       = '0;
        extra     = '0;
        full_next = '0;
        for (int c = 0; c < COLS; c++) begin
            cap[c]       = output_col_valid[c] && phase[c] == '0 && row_ptr[c] < IW'(ROWS);
            extra[c]     = output_col_valid[c] && phase[c] == '0 && row_ptr[c] == IW'(ROWS);
            full_next[c] = row_ptr[c] == IW'(ROWS) || (cap[c] && row_ptr[c] == IW'(ROWS - 1));
        end
    end

    // drained row is a mux of buffer registers, zero whenever no row is offered
    always_comb begin
        out_row_data = '0;
        for (int c = 0; c < COLS; c++)
            out_row_data[c*WORD_SIZE +: WORD_SIZE] = out_valid ? rbuf[out_row_idx[AW-1:0]][c] : '0;
    end

    // result buffer capture; contents need no reset
    always_ff @(posedge clk) begin
        if (rst && state == COLLECT && !start)
            for (int c = 0; c < COLS; c++)
                if (cap[c])
                    rbuf[row_ptr[c][AW-1:0]][c] <= bottom_out[c*WORD_SIZE +: WORD_SIZE];
    end

    // control FSM: pointers, hold-window phase, drain handshake and status flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_row_idx <= '0;
            done        <= 1'b0;
            overrun     <= 1'b0;
            for (int c = 0; c < COLS; c++) begin
                row_ptr[c] <= '0;
                phase[c]   <= '0;
            end
        end else begin
            done <= 1'b0;
            for (int c = 0; c < COLS; c++)
                phase[c] <= (!output_col_valid[c] || phase[c] == PHW'(HOLD_CYCLES - 1)) ? '0 : phase[c] + 1'b1;
            if (start && state != DRAIN) begin
                state   <= COLLECT;
                overrun <= 1'b0;
                for (int c = 0; c < COLS; c++) begin
                    row_ptr[c] <= '0;
                    phase[c]   <= '0;
                end
            end else if (state == COLLECT) begin
                for (int c = 0; c < COLS; c++)
                    if (cap[c])
                        row_ptr[c] <= row_ptr[c] + 1'b1;
                if (|extra)
                    overrun <= 1'b1;
                if (&full_next) begin
                    state       <= DRAIN;
                    out_valid   <= 1'b1;
                    out_row_idx <= '0;
                end
            end else if (state == DRAIN) begin
                if (|extra)
                    overrun <= 1'b1;
                if (out_ready) begin
                    if (out_row_idx == IW'(ROWS - 1)) begin
                        out_valid   <= 1'b0;
                        done        <= 1'b1;
                        state       <= IDLE;
                        out_row_idx <= '0;
                    end else begin
                        out_row_idx <= out_row_idx + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_systolic_output_collector.sv
// tb_systolic_output_collector: table-driven streams with a row scoreboard for the output collector
module tb_systolic_output_collector;
    localparam int R = 2, C = 2, W = 16, H = 2;

    logic           clk = 0, rst = 0, start = 0, out_ready = 1;
    logic [C*W-1:0] bottom_out = '0;
    logic [C-1:0]   output_col_valid = '0;
    logic [C*W-1:0] out_row_data;
    logic [1:0]     out_row_idx;
    logic           out_valid, busy, done, overrun;

    systolic_output_collector #(.ROWS(R), .COLS(C), .WORD_SIZE(W), .HOLD_CYCLES(H)) dut (
        .clk(clk), .rst(rst), .start(start), .bottom_out(bottom_out),
        .output_col_valid(output_col_valid), .out_row_data(out_row_data),
        .out_row_idx(out_row_idx), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0][15:0] a, b;
        int               na, nb;
        logic [15:0]      glitch;
        logic             ovr;
    } vec_t;

    typedef struct {
        logic [1:0]  idx;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_chk = 0, n_fail = 0, done_cnt = 0;
    vec_t vt[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] a0, a1, a2, b0, b1, b2,
                                input int na, nb, input logic [15:0] g, input logic ovr);
        vec_t v;
        v.a = {a2, a1, a0};
        v.b = {b2, b1, b0};
        v.na = na;
        v.nb = nb;
        v.glitch = g;
        v.ovr = ovr;
        return v;
    endfunction

    // column 0 starts at cycle 0, column 1 one window later; glitch replaces the second cycle of each window
    task automatic drive(input vec_t v, input int i);
        output_col_valid = '0;
        bottom_out = '0;
        if (i < 2 * v.na) begin
            output_col_valid[0] = 1'b1;
            bottom_out[15:0] = (i % 2 == 1 && v.glitch != 0) ? v.glitch : v.a[i/2];
        end
        if (i >= 2 && i - 2 < 2 * v.nb) begin
            output_col_valid[1] = 1'b1;
            bottom_out[31:16] = ((i - 2) % 2 == 1 && v.glitch != 0) ? v.glitch : v.b[(i-2)/2];
        end
    endtask

    task automatic push_exp(input vec_t v);
        sb.push_back('{2'd0, {v.b[0], v.a[0]}});
        sb.push_back('{2'd1, {v.b[1], v.a[1]}});
    endtask

    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        start = 1;
        out_ready = 1;
        done_cnt = 0;
        push_exp(v);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            start = 0;
            drive(v, i);
            if (i == 0) begin
                chk("start_clears_overrun", 32'(overrun), 0);
                chk("busy_collect", 32'(busy), 1);
            end
            if (i == 4) chk("no_early_valid", 32'(out_valid), 0);
            if (i == 5) chk("first_row_latency", 32'(out_valid), 1);
        end
        chk("done_once", done_cnt, 1);
        chk("overrun", 32'(overrun), 32'(v.ovr));
        chk("busy_after_done", 32'(busy), 0);
        chk("rows_drained", sb.size(), 0);
        sb.delete();
    endtask

    // scoreboard: every accepted row must match the oldest expected row
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_row", {30'd0, out_row_idx}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("row_idx", 32'(out_row_idx), 32'(e.idx));
                chk("row_data", out_row_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = mk(16'h0011, 16'h0021, 16'h0000, 16'h0012, 16'h0022, 16'h0000, 2, 2, 16'h0000, 1'b0);
        vt[1] = mk(16'h0011, 16'h0021, 16'h0000, 16'h0012, 16'h0022, 16'h0000, 2, 2, 16'h00FF, 1'b0);
        vt[2] = mk(16'h0011, 16'h0021, 16'h0031, 16'h0012, 16'h0022, 16'h0000, 3, 2, 16'h0000, 1'b1);
        vt[3] = mk(16'h0011, 16'h0021, 16'h0000, 16'h0012, 16'h0022, 16'h0032, 2, 3, 16'h0000, 1'b1);
        vt[4] = mk(16'hAAAA, 16'h5555, 16'h0000, 16'hFFFF, 16'h0001, 16'h0000, 2, 2, 16'h0000, 1'b0);

        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_row_idx", 32'(out_row_idx), 0);
        chk("rst_out_row_data", out_row_data, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_overrun", 32'(overrun), 0);
        rst = 1;

        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            drive(vt[2], i);
            chk("idle_busy", 32'(busy), 0);
        end
        @(posedge clk); #1;
        drive(vt[0], 20);
        chk("idle_out_valid", 32'(out_valid), 0);
        chk("idle_overrun", 32'(overrun), 0);

        for (int k = 0; k < 5; k++) run_vec(vt[k]);

        @(posedge clk); #1;
        start = 1;
        done_cnt = 0;
        out_ready = 0;
        push_exp(vt[0]);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            start = 0;
            drive(vt[0], i);
            if (i >= 5) begin
                chk("bp_valid", 32'(out_valid), 1);
                chk("bp_idx", 32'(out_row_idx), 0);
                chk("bp_data", out_row_data, {vt[0].b[0], vt[0].a[0]});
            end
        end
        @(posedge clk); #1;
        out_ready = 1;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_done_once", done_cnt, 1);
        chk("bp_rows_drained", sb.size(), 0);
        chk("bp_busy", 32'(busy), 0);
        sb.delete();

        @(posedge clk); #1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        output_col_valid = 2'b01;
        bottom_out = 32'h0000_DEAD;
        @(posedge clk); #1;
        output_col_valid = '0;
        bottom_out = '0;
        run_vec(vt[4]);

        @(posedge clk); #1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        drive(vt[3], 0);
        @(posedge clk); #1;
        drive(vt[3], 1);
        rst = 0;
        @(posedge clk); #1;
        rst = 1;
        drive(vt[3], 20);
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_overrun", 32'(overrun), 0);
        for (int i = 2; i < 8; i++) begin
            @(posedge clk); #1;
            drive(vt[3], i);
        end
        chk("mid_rst_stays_idle", 32'(busy), 0);
        run_vec(vt[4]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
